// File: rtl/scv_rominit_ctl.sv
// Steers host download bytes onto the SCV boot/chr/cart ROM-init port and holds the core in reset until boot and chr images are complete.
// Optional build macro SCV_ROMINIT_ADDRCHK_EN: drop and flag any write whose DL_ADDR differs from the running byte count.
module scv_rominit_ctl #(
    parameter int unsigned BOOT_SIZE = 4096,
    parameter int unsigned CHR_SIZE  = 1024,
    parameter int unsigned CART_MAX  = 131072,
    parameter int unsigned RES_HOLD  = 16
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        DL_ACTIVE,
    input  logic [7:0]  DL_INDEX,
    input  logic [24:0] DL_ADDR,
    input  logic [7:0]  DL_DATA,
    input  logic        DL_WR,
    output logic        DL_WAIT,
    output logic        ROMINIT_SEL_BOOT,
    output logic        ROMINIT_SEL_CHR,
    output logic        ROMINIT_SEL_CART,
    output logic [24:0] ROMINIT_ADDR,
    output logic [7:0]  ROMINIT_DATA,
    output logic        ROMINIT_VALID,
    output logic [24:0] CART_SIZE,
    output logic        CORE_RES,
    output logic        ERR
);

    localparam int HW = ($clog2(RES_HOLD + 1) > 5) ? $clog2(RES_HOLD + 1) : 5;
    localparam logic [24:0] BOOT_LIM = 25'(BOOT_SIZE);
    localparam logic [24:0] CHR_LIM  = 25'(CHR_SIZE);
    localparam logic [24:0] CART_LIM = 25'(CART_MAX);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FIN, S_HOLD} state_t;

    state_t          state;
    logic [1:0]      idx;
    logic [24:0]     cnt;
    logic [HW-1:0]   hcnt;
    logic            boot_ok;
    logic            chr_ok;
    logic [2:0]      sel;

    logic            vld_p1;
    logic [24:0]     addr_p1;
    logic [7:0]      data_p1;

    logic            start_ok;
    logic            wr_en;
    logic            wr_over;
    logic            addr_bad;
    logic            wr_take;
    logic            wr_err;
    logic [1:0]      wr_idx;
    logic [24:0]     wr_cnt;

    function automatic logic [24:0] limit_of(input logic [1:0] i);
        case (i)
            2'd0:    return BOOT_LIM;
            2'd1:    return CHR_LIM;
            default: return CART_LIM;
        endcase
    endfunction

    function automatic logic [2:0] sel_of(input logic [1:0] i);
        return 3'b001 << i;
    endfunction

    assign start_ok = DL_ACTIVE && (DL_INDEX < 8'd3);

    // A write in the DL_ACTIVE rise cycle is evaluated against the incoming index with cnt = 0.
    always_comb begin
        wr_idx  = (state == S_LOAD) ? idx : DL_INDEX[1:0];
        wr_cnt  = (state == S_LOAD) ? cnt : 25'd0;
        wr_en   = DL_WR && ((state == S_LOAD) ||
                  (((state == S_IDLE) || (state == S_HOLD)) && start_ok));
        wr_over = (wr_cnt >= limit_of(wr_idx));
        wr_take = wr_en && !wr_over && !addr_bad;
        wr_err  = wr_en && (wr_over || addr_bad);
    end

`ifdef SCV_ROMINIT_ADDRCHK_EN
    assign addr_bad = (DL_ADDR != wr_cnt);
`else
    logic unused_addr;
    assign unused_addr = ^DL_ADDR;
    assign addr_bad    = 1'b0;
`endif

    // Stage p0 -> p1: accepted byte becomes a one-cycle ROM-init write.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state     <= S_IDLE;
            idx       <= 2'd0;
            cnt       <= 25'd0;
            hcnt      <= '0;
            boot_ok   <= 1'b0;
            chr_ok    <= 1'b0;
            sel       <= 3'b000;
            ERR       <= 1'b0;
            CART_SIZE <= 25'd0;
            vld_p1    <= 1'b0;
            addr_p1   <= 25'd0;
            data_p1   <= 8'd0;
        end else begin
            vld_p1 <= wr_take;
            if (wr_take) begin
                addr_p1 <= wr_cnt;
                data_p1 <= DL_DATA;
            end
            if (wr_err)
                ERR <= 1'b1;

            case (state)
                S_IDLE, S_HOLD: begin
                    if (start_ok) begin
                        idx   <= DL_INDEX[1:0];
                        cnt   <= 25'(wr_take);
                        sel   <= sel_of(DL_INDEX[1:0]);
                        state <= S_LOAD;
                    end else if (state == S_HOLD) begin
                        if (hcnt <= HW'(1))
                            state <= S_IDLE;
                        if (hcnt != '0)
                            hcnt <= hcnt - HW'(1);
                    end
                end
                S_LOAD: begin
                    if (wr_take)
                        cnt <= cnt + 25'd1;
                    if (!DL_ACTIVE)
                        state <= S_FIN;
                end
                S_FIN: begin
                    case (idx)
                        2'd0: begin
                            boot_ok <= (cnt == BOOT_LIM);
                            if (cnt != BOOT_LIM)
                                ERR <= 1'b1;
                        end
                        2'd1: begin
                            chr_ok <= (cnt == CHR_LIM);
                            if (cnt != CHR_LIM)
                                ERR <= 1'b1;
                        end
                        default: begin
                            CART_SIZE <= cnt;
                            if (cnt == 25'd0)
                                ERR <= 1'b1;
                        end
                    endcase
                    hcnt  <= HW'(RES_HOLD);
                    sel   <= 3'b000;
                    state <= S_HOLD;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A byte still in flight when RES rises never reaches the ROM.
    assign ROMINIT_VALID    = vld_p1 && !RES;
    assign ROMINIT_ADDR     = addr_p1;
    assign ROMINIT_DATA     = data_p1;
    assign ROMINIT_SEL_BOOT = sel[0];
    assign ROMINIT_SEL_CHR  = sel[1];
    assign ROMINIT_SEL_CART = sel[2];
    assign DL_WAIT          = RES || (state == S_FIN);
    assign CORE_RES         = !((state == S_IDLE) && boot_ok && chr_ok);

endmodule

// File: doc/scv_rominit_ctl.md
# scv_rominit_ctl

Sequences host ROM downloads into the Super Cassette Vision core's ROM-init port. A byte stream tagged with an index is steered onto the boot, character and cart ROM select lines. The block holds the core in reset until the boot and character ROMs are complete, and tracks the loaded cart size. It sits between the platform download interface and the `scv` top-level ROMINIT_* / RESB inputs.

## Interface
Parameters:
- BOOT_SIZE, 4096: exact byte count required for the µPD7801 internal ROM image.
- CHR_SIZE, 1024: exact byte count required for the EPOCH TV-1 character ROM.
- CART_MAX, 131072: maximum accepted cart bytes.
- RES_HOLD, 16: cycles CORE_RES is held after the last load finishes.

Ports:
- CLK  in  1  system clock (28.636 MHz).
- RES  in  1  reset, synchronous, active-high.
- DL_ACTIVE  in  1  download in progress.
- DL_INDEX  in  8  0 = boot, 1 = chr, 2 = cart; any other value is ignored.
- DL_ADDR  in  25  byte address of DL_DATA.
- DL_DATA  in  8  download byte.
- DL_WR  in  1  DL_DATA/DL_ADDR valid this cycle.
- DL_WAIT  out  1  host must stall; DL_WR is not accepted while high.
- ROMINIT_SEL_BOOT / _CHR / _CART  out  1 each  one-hot target select.
- ROMINIT_ADDR  out  25  write address.
- ROMINIT_DATA  out  8  write data.
- ROMINIT_VALID  out  1  single-cycle write strobe.
- CART_SIZE  out  25  bytes in last completed cart load.
- CORE_RES  out  1  active-high reset to core; drive RESB = ~CORE_RES.
- ERR  out  1  sticky load error.

## Operation
- Reset values:
  - all SEL, VALID, ERR and CART_SIZE are 0;
  - ROMINIT_ADDR and ROMINIT_DATA are 0;
  - DL_WAIT = 1 while RES is high, else 0;
  - CORE_RES = 1.
- Internal state:
  - loaded flags boot_ok and chr_ok, cleared by RES;
  - 25-bit byte counter cnt;
  - 5-bit (or wider) hold counter hcnt.
- FSM states: IDLE, LOAD, FIN, HOLD.
- IDLE:
  - On DL_ACTIVE=1 with DL_INDEX in {0,1,2}: latch the index, cnt=0, ERR unchanged, go to LOAD.
  - An unknown index stays in IDLE and drops all writes silently.
- LOAD:
  - The SEL bit matching the latched index is 1; the others are 0.
  - Each DL_WR: if cnt < limit (BOOT_SIZE / CHR_SIZE / CART_MAX), output ROMINIT_ADDR=cnt, ROMINIT_DATA=DL_DATA, VALID=1, then cnt++.
  - If cnt ≥ limit, drop the write and set ERR.
  - DL_ACTIVE=0 goes to FIN. DL_INDEX changes during LOAD are ignored.
- FIN (1 cycle):
  - SEL is held, VALID=0, DL_WAIT=1.
  - Boot: boot_ok = (cnt==BOOT_SIZE). Chr: chr_ok = (cnt==CHR_SIZE). A short image clears the flag and sets ERR.
  - Cart: CART_SIZE=cnt. cnt==0 sets ERR.
  - Load hcnt=RES_HOLD, go to HOLD.
- HOLD:
  - SEL is 0 and hcnt decrements.
  - At hcnt==0, go to IDLE.
  - DL_ACTIVE=1 in HOLD goes directly to LOAD, following the IDLE rules.
- CORE_RES = 1 unless (state==IDLE and boot_ok and chr_ok). A cart load therefore re-resets the core for its duration plus RES_HOLD+1 cycles.
- ERR clears only on RES.
- RES mid-load: forces IDLE and clears the flags. Any VALID in flight is suppressed in the same cycle; a partial image is never marked loaded.

## Timing
- DL_WR accepted in cycle n → ROMINIT_VALID=1 in n+1, with ADDR/DATA stable for that cycle. Latency is 1 and the block accepts one byte per cycle.
- DL_WR in the same cycle as the DL_ACTIVE rise (from IDLE) is accepted: SEL and VALID both rise in n+1.
- SEL falls 2 cycles after DL_ACTIVE falls (the FIN cycle in between).
- DL_WAIT is high only in FIN and during RES. DL_WR while DL_WAIT is high is ignored.
- CORE_RES falls in the first IDLE cycle with both flags set, i.e. RES_HOLD+2 cycles after the DL_ACTIVE fall of the completing load.

## Configuration
- SCV_ROMINIT_ADDRCHK_EN defined:
  - every accepted DL_WR compares DL_ADDR with cnt;
  - on mismatch the write is dropped, ERR is set, and cnt does not advance.
- Not defined: DL_ADDR is ignored and addresses come only from cnt.

## Test plan
- Boot load: 4096 sequential bytes, then DL_ACTIVE fall → VALID×4096 with ROMINIT_SEL_BOOT=1 and addresses 0..4095. After FIN, boot_ok is set; CORE_RES stays 1 because chr is not yet loaded.
- Chr load of 1024 bytes after boot → CORE_RES falls exactly RES_HOLD+2 cycles after the DL_ACTIVE fall; ERR=0.
- Cart load of 32768 bytes after boot+chr → CORE_RES rises 1 cycle after the DL_ACTIVE rise, CART_SIZE=32768, then CORE_RES falls again after hold.
- Short boot (4000 bytes) → ERR=1, boot_ok=0, CORE_RES stays 1. Cart of CART_MAX+1 bytes → last byte dropped, ERR=1.
- RES asserted at byte 500 of a chr load → VALID=0 and SEL=0 next cycle, CORE_RES=1, flags cleared.
- With SCV_ROMINIT_ADDRCHK_EN: DL_ADDR skips from 9 to 11 → byte dropped, ERR=1, next VALID at ROMINIT_ADDR=10. Without the macro, the same stimulus loads sequentially with ERR=0. DL_INDEX=5 → no SEL and no VALID.
